// File: rtl/carrier_acq_ctrl_if.sv
// Control and status bundle between the carrier acquisition sequencer and
// the block that owns the Costas loop (run request, FCW plan, lock status).
interface carrier_acq_ctrl_if;
   logic        enable;
   logic [31:0] nominal_fcw;
   logic [31:0] sweep_step;
   logic        raw_locked;
   logic [31:0] center_freq;
   logic        loop_rst_n;
   logic        acq_locked;
   logic        acq_fail;
   logic [2:0]  state_o;
   logic [7:0]  pos_idx;

   modport master (
      output enable, nominal_fcw, sweep_step, raw_locked,
      input  center_freq, loop_rst_n, acq_locked, acq_fail, state_o, pos_idx
   );

   modport slave (
      input  enable, nominal_fcw, sweep_step, raw_locked,
      output center_freq, loop_rst_n, acq_locked, acq_fail, state_o, pos_idx
   );
endinterface

// File: rtl/carrier_acq_ctrl.sv
// Carrier acquisition sequencer: sweeps the Costas loop center frequency around
// nominal (0,+1,-1,+2,-2,...) until lock is qualified, then supervises loss of lock.
module carrier_acq_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int DWELL_CYC  = 4096,
   parameter int LOCK_CNT   = 1024,
   parameter int UNLOCK_CNT = 256,
   parameter int SWEEP_N    = 8
) (
   input logic               clk,
   input logic               reset,
   carrier_acq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      DWELL  = 3'd2,
      LOCKED = 3'd3,
      FAIL   = 3'd4
   } state_e;

   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
   localparam int DWELL_W  = $clog2(DWELL_CYC + 1);
   localparam int LOCK_W   = $clog2(LOCK_CNT + 1);
   localparam int UNLOCK_W = $clog2(UNLOCK_CNT + 1);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYC - 1);
   localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_CNT - 1);
   localparam logic [UNLOCK_W-1:0] UNLOCK_LAST = UNLOCK_W'(UNLOCK_CNT - 1);
   localparam logic [7:0]          LAST_POS    = 8'(2 * SWEEP_N);

   state_e              state;
   logic [7:0]          pos;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [DWELL_W-1:0]  dwell_cnt;
   logic [LOCK_W-1:0]   lock_cnt;
   logic [UNLOCK_W-1:0] unlock_cnt;
   logic [31:0]         center_freq_q;
   logic                loop_rst_q;
   logic                locked_q;
   logic                fail_q;

   logic [7:0]          k_next;
   logic [6:0]          mag;
   logic [31:0]         step_off;
   logic [31:0]         entry_freq;

   // Frequency for the position about to be entered. Only DWELL advances the
   // sweep; every other way into SETTLE restarts at position 0.
   always_comb begin
      // NOTE: every variable is assigned on every pass, so no latch is inferred.
      k_next     = (state == DWELL) ? pos + 8'd1 : 8'd0;
      mag        = k_next[7:1] + {6'd0, k_next[0]};
      step_off   = bus.sweep_step * {25'd0, mag};
      entry_freq = k_next[0] ? bus.nominal_fcw + step_off
                             : bus.nominal_fcw - step_off;
   end

   // NOTE: state and outputs use non-blocking assignments so every register
   // updates from pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         pos           <= 8'd0;
         settle_cnt    <= '0;
         dwell_cnt     <= '0;
         lock_cnt      <= '0;
         unlock_cnt    <= '0;
         center_freq_q <= 32'd0;
         loop_rst_q    <= 1'b0;
         locked_q      <= 1'b0;
         fail_q        <= 1'b0;
      end else if (!bus.enable) begin
         state         <= IDLE;
         pos           <= 8'd0;
         settle_cnt    <= '0;
         dwell_cnt     <= '0;
         lock_cnt      <= '0;
         unlock_cnt    <= '0;
         center_freq_q <= bus.nominal_fcw;
         loop_rst_q    <= 1'b0;
         locked_q      <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state         <= SETTLE;
               pos           <= 8'd0;
               settle_cnt    <= '0;
               dwell_cnt     <= '0;
               lock_cnt      <= '0;
               center_freq_q <= entry_freq;
               loop_rst_q    <= 1'b0;
            end

            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= DWELL;
                  dwell_cnt  <= '0;
                  lock_cnt   <= '0;
                  loop_rst_q <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
               end
            end

            DWELL: begin
               // Lock qualification wins over dwell expiry on the same edge.
               if (bus.raw_locked && lock_cnt == LOCK_LAST) begin
                  state      <= LOCKED;
                  unlock_cnt <= '0;
                  locked_q   <= 1'b1;
               end else if (dwell_cnt == DWELL_LAST) begin
                  if (pos != LAST_POS) begin
                     state         <= SETTLE;
                     pos           <= k_next;
                     settle_cnt    <= '0;
                     dwell_cnt     <= '0;
                     lock_cnt      <= '0;
                     center_freq_q <= entry_freq;
                     loop_rst_q    <= 1'b0;
                  end else begin
                     state         <= FAIL;
                     center_freq_q <= bus.nominal_fcw;
                     loop_rst_q    <= 1'b0;
                     fail_q        <= 1'b1;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DWELL_W'(1);
                  lock_cnt  <= bus.raw_locked ? lock_cnt + LOCK_W'(1) : '0;
               end
            end

            LOCKED: begin
               if (bus.raw_locked) begin
                  unlock_cnt <= '0;
               end else if (unlock_cnt == UNLOCK_LAST) begin
                  state         <= SETTLE;
                  pos           <= 8'd0;
                  settle_cnt    <= '0;
                  dwell_cnt     <= '0;
                  lock_cnt      <= '0;
                  unlock_cnt    <= '0;
                  center_freq_q <= entry_freq;
                  loop_rst_q    <= 1'b0;
                  locked_q      <= 1'b0;
               end else begin
                  unlock_cnt <= unlock_cnt + UNLOCK_W'(1);
               end
            end

            FAIL: begin
               center_freq_q <= bus.nominal_fcw;
            end

            default: begin
               state         <= IDLE;
               pos           <= 8'd0;
               center_freq_q <= bus.nominal_fcw;
               loop_rst_q    <= 1'b0;
               locked_q      <= 1'b0;
               fail_q        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.center_freq = center_freq_q;
   assign bus.loop_rst_n  = loop_rst_q;
   assign bus.acq_locked  = locked_q;
   assign bus.acq_fail    = fail_q;
   assign bus.state_o     = state;
   assign bus.pos_idx     = pos;

endmodule
